uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serializing half of the on-chip UART. It takes one byte from the CPU store path through a ready/valid handshake and drives it onto the serial TX line as an 8N1 frame.
- Its data_in_ready output is the TX-ready status bit that the MMIO read mux returns at UART control offset 0, bit 0.
- Single clock domain.

Parameters:
- CLOCK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: serial line rate in bits/s.
- Derived constant SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division, truncating). This is the number of clk cycles each bit is held. Counter width is clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserted when 0; deassertion is taken synchronously by the surrounding reset logic.
- data_in  input  8  byte to transmit; sampled only on handshake.
- data_in_valid  input  1  producer has a byte on data_in.
- data_in_ready  output  1  transmitter can accept a byte this cycle.
- serial_out  output  1  TX line; idle level is 1.

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, serial_out=1, data_in_ready=1, bit counter=0, cycle counter=0, shift register=0. Reset in mid-frame aborts the frame immediately and the line returns to 1 with no glitch to 0.
- Outputs are registered. serial_out and data_in_ready come straight from flops, never combinationally from inputs.
- Handshake: a transfer occurs on a rising edge where data_in_valid && data_in_ready.
  - data_in is latched into the shift register on that edge.
  - data_in_ready deasserts on the same edge.
  - data_in_valid without data_in_ready is ignored and has no side effects. The producer must hold the byte.
- FSM states:
  - IDLE: serial_out=1, data_in_ready=1. On handshake go to START and clear the cycle counter.
  - START: serial_out=0 for exactly SYMBOL_EDGE_TIME cycles, then go to DATA with bit index 0.
  - DATA: serial_out = shift[bit index], LSB first. Each bit is held SYMBOL_EDGE_TIME cycles. After bit 7 completes, go to STOP.
  - STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles, then go to IDLE.
- Latency: serial_out falls on the first edge after the handshake edge.
- Frame timing:
  - A full frame is exactly 10*SYMBOL_EDGE_TIME cycles from the serial_out falling edge to the end of the stop bit.
  - data_in_ready reasserts on the edge that ends the stop bit.
  - A back-to-back byte may be accepted on that same edge. The next start bit then follows with no extra idle cycle, giving continuous streaming at line rate.
- Cycle counter:
  - Counts 0..SYMBOL_EDGE_TIME-1, then wraps to 0 on each symbol boundary.
  - Held at 0 in IDLE.
  - Never exceeds SYMBOL_EDGE_TIME-1.
- Bit index: 3 bits, incremented only at DATA symbol boundaries, reset to 0 on entering DATA.
- Changes on data_in after the handshake edge must not affect the frame in flight.
- Simultaneous events: an asserted reset wins over any handshake or symbol boundary.

Test Plan:
- Reset: hold rst=0 for 5 cycles with data_in_valid=1 -> serial_out=1 and data_in_ready=1 throughout. No frame starts until after rst rises and a handshake occurs.
- Single byte, CLOCK_FREQ=1000 and BAUD_RATE=100 (10 cycles/bit), send 0xA5:
  - serial_out reads 0, 1,0,1,0,0,1,0,1, 1, each level held exactly 10 cycles (100 cycles total).
  - data_in_ready stays low for exactly 100 cycles.
- Back-to-back: send 0x00 then 0xFF with data_in_valid held high.
  - Second start bit begins exactly 100 cycles after the first.
  - No idle gap between the frames.
  - Decoded bytes are 0x00 and 0xFF.
- Data stability: handshake 0x3C, then drive data_in=0xC3 for the rest of the frame -> line still carries 0x3C.
- Reset mid-frame: assert rst=0 during data bit 4 of 0x55 -> serial_out=1 within the same cycle (asynchronous). After release, data_in_ready=1, and a new byte 0x81 transmits correctly.
- Stall: data_in_valid pulsed for one cycle while data_in_ready=0 -> pulse ignored, and exactly one frame is emitted.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 serializer: accepts one byte over valid/ready and shifts it out LSB first, SYMBOL_EDGE_TIME clocks per bit.
// serial_out falls one edge after the accepting edge; data_in_ready is low while a frame is in flight.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_idx_nxt;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_nxt;
   logic             r_serial_out;
   logic             w_serial_nxt;
   logic             r_ready;
   logic             w_ready_nxt;
   logic             w_fire;
   logic             w_sym_end;

   assign w_fire    = data_in_valid && r_ready;
   assign w_sym_end = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_serial_out <= 1'b1;
         r_ready      <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_shift      <= w_shift_nxt;
         r_serial_out <= w_serial_nxt;
         r_ready      <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_serial_nxt  = 1'b1;

      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_fire) begin
               w_state_nxt = START;
               w_shift_nxt = data_in;
            end
         end
         START: begin
            if (w_sym_end) begin
               w_state_nxt   = DATA;
               w_bit_idx_nxt = 3'd0;
               w_cnt_nxt     = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DATA: begin
            if (w_sym_end) begin
               w_cnt_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STOP: begin
            // Ready is only high in the last stop cycle, so a fire here always lands on the boundary.
            if (w_sym_end) begin
               w_cnt_nxt = '0;
               if (w_fire) begin
                  w_state_nxt = START;
                  w_shift_nxt = data_in;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Ready rises for the final stop cycle so a waiting byte is taken on the stop boundary edge,
      // keeping back-to-back frames gap-free.
      w_ready_nxt = (w_state_nxt == IDLE) || ((w_state_nxt == STOP) && (w_cnt_nxt == CNT_LAST));

      case (r_state)
         START:   w_serial_nxt = 1'b0;
         DATA:    w_serial_nxt = r_shift[r_bit_idx];
         default: w_serial_nxt = 1'b1;
      endcase
   end

   assign serial_out    = r_serial_out;
   assign data_in_ready = r_ready;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter at 10 clocks per bit: the driver queues each accepted byte,
// and a line monitor decodes every frame and compares it against the queue.
`timescale 1ns/1ps
module tb_uart_transmitter;

   localparam int S = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;

   typedef struct packed {
      logic [7:0] b;
      int         fall;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   frames_seen = 0;
   int   last_fall = 0;
   int   prev_fall = 0;
   bit   mon_busy = 1'b0;
   logic smp [100];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_transmitter #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out   (serial_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
   task automatic send(input logic [7:0] b, output int hs);
      int n;
      data_in       = b;
      data_in_valid = 1'b1;
      n = 0;
      while (!data_in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 500), 1);
      hs = cyc + 1;
      exp_q.push_back('{b: b, fall: hs + 1});
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 3000), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic abort_at(input int k);
      int         hs;
      logic [7:0] v;
      v = 8'h55;
      send(v, hs);
      data_in_valid = 1'b0;
      repeat (15 + S * k) @(posedge clk);
      #2;
      chk("line_before_reset", serial_out, v[k]);
      rst = 1'b0;
      #1;
      chk("async_reset_line", serial_out, 1);
      chk("async_reset_ready", data_in_ready, 1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", data_in_ready, 1);
   endtask

   // Line monitor: frame decode, symbol width and timing checks.
   initial begin
      logic       prev;
      logic [7:0] got;
      int         fall;
      int         bad;
      bit         abort;
      exp_t       e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 1'b1;
            continue;
         end
         if (prev && !serial_out) begin
            mon_busy = 1'b1;
            fall  = cyc;
            abort = 1'b0;
            for (int s = 0; s < 100; s++) begin
               if (s > 0) @(negedge clk);
               if (!rst) begin
                  abort = 1'b1;
                  break;
               end
               smp[s] = serial_out;
            end
            if (!abort) begin
               bad = 0;
               for (int j = 0; j < 10; j++)
                  for (int k = 0; k < 10; k++)
                     if (smp[j*10+k] !== smp[j*10]) bad++;
               for (int j = 0; j < 8; j++) got[j] = smp[(j+1)*10];
               chk("symbol_hold", bad, 0);
               chk("start_stop", {smp[0], smp[90]}, 2'b01);
               chk("frame_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("byte", got, e.b);
                  chk("fall_cycle", fall, e.fall);
               end
               frames_seen++;
               prev_fall = last_fall;
               last_fall = fall;
               prev = smp[99];
            end else begin
               prev = 1'b1;
            end
            mon_busy = 1'b0;
         end else begin
            prev = serial_out;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
      $fatal(1);
   end

   initial begin
      int hs;
      int hs2;
      int n;
      int f0;

      data_in_valid = 1'b1;
      data_in       = 8'hAA;
      repeat (5) begin
         @(negedge clk);
         chk("reset_serial", serial_out, 1);
         chk("reset_ready", data_in_ready, 1);
      end
      data_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_frame_without_handshake", frames_seen + int'(mon_busy), 0);

      send(8'hA5, hs);
      data_in_valid = 1'b0;
      chk("ready_low_after_accept", data_in_ready, 0);
      n = 0;
      while (!data_in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ready_window", cyc + 1 - hs, 100);
      wait_idle();

      send(8'h00, hs);
      data_in = 8'hFF;
      send(8'hFF, hs2);
      data_in_valid = 1'b0;
      chk("b2b_accept_spacing", hs2 - hs, 100);
      wait_idle();
      chk("b2b_start_spacing", last_fall - prev_fall, 100);

      send(8'h3C, hs);
      data_in_valid = 1'b0;
      data_in       = 8'hC3;
      wait_idle();

      f0 = frames_seen;
      send(8'h96, hs);
      data_in_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("stall_ready_low", data_in_ready, 0);
      data_in       = 8'h69;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      wait_idle();
      repeat (150) @(negedge clk);
      chk("stall_one_frame", frames_seen - f0, 1);

      abort_at(4);
      send(8'h81, hs);
      data_in_valid = 1'b0;
      wait_idle();

      abort_at(5);
      send(8'h5A, hs);
      data_in_valid = 1'b0;
      wait_idle();

      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
